// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with position counters, syncs, blanking, strobes and frame count
module video_timing_gen #(
    parameter int H_DISPLAY  = 256,
    parameter int H_BACK     = 23,
    parameter int H_FRONT    = 7,
    parameter int H_SYNC     = 23,
    parameter int V_DISPLAY  = 240,
    parameter int V_TOP      = 5,
    parameter int V_BOTTOM   = 14,
    parameter int V_SYNC     = 3,
    parameter int H_BITS     = 9,
    parameter int V_BITS     = 9,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int FRAME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    output logic [H_BITS-1:0]     hpos,
    output logic [V_BITS-1:0]     vpos,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_on,
    output logic                  hblank,
    output logic                  vblank,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_count
);
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    if (H_MAX >= (1 << H_BITS)) begin : g_hbits_chk
        $error("video_timing_gen: H_BITS too narrow for H_MAX");
    end
    if (V_MAX >= (1 << V_BITS)) begin : g_vbits_chk
        $error("video_timing_gen: V_BITS too narrow for V_MAX");
    end

    localparam logic [H_BITS-1:0] H_DISP_L = H_BITS'(H_DISPLAY);
    localparam logic [H_BITS-1:0] H_SS_L   = H_BITS'(H_SYNC_START);
    localparam logic [H_BITS-1:0] H_SE_L   = H_BITS'(H_SYNC_END);
    localparam logic [H_BITS-1:0] H_MAX_L  = H_BITS'(H_MAX);
    localparam logic [V_BITS-1:0] V_DISP_L = V_BITS'(V_DISPLAY);
    localparam logic [V_BITS-1:0] V_SS_L   = V_BITS'(V_SYNC_START);
    localparam logic [V_BITS-1:0] V_SE_L   = V_BITS'(V_SYNC_END);
    localparam logic [V_BITS-1:0] V_MAX_L  = V_BITS'(V_MAX);

    logic                  run_q;
    logic [H_BITS-1:0]     hpos_q, hpos_d;
    logic [V_BITS-1:0]     vpos_q, vpos_d;
    logic [FRAME_BITS-1:0] fc_q, fc_d;
    logic                  adv, h_end, v_end;

    assign adv   = pix_en & run_q;
    assign h_end = hpos_q == H_MAX_L;
    assign v_end = vpos_q == V_MAX_L;

    // reset release synchroniser: counting is held off until one clean edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // next raster position and frame count
    always_comb begin
        hpos_d = h_end ? '0 : hpos_q + 1'b1;
        vpos_d = h_end ? (v_end ? '0 : vpos_q + 1'b1) : vpos_q;
        fc_d   = (h_end && v_end) ? fc_q + 1'b1 : fc_q;
    end

    // position and frame counters advance once per enabled pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hpos_q <= '0;
            vpos_q <= '0;
            fc_q   <= '0;
        end else if (adv) begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            fc_q   <= fc_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_count = fc_q;
    assign hblank      = hpos_q >= H_DISP_L;
    assign vblank      = vpos_q >= V_DISP_L;
    assign display_on  = !hblank && !vblank;
    assign hsync       = (hpos_q >= H_SS_L && hpos_q <= H_SE_L) ? HSYNC_POL : ~HSYNC_POL;
    assign vsync       = (vpos_q >= V_SS_L && vpos_q <= V_SE_L) ? VSYNC_POL : ~VSYNC_POL;
    assign line_start  = adv && hpos_q == '0;
    assign frame_start = line_start && vpos_q == '0;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed vectors and sequences for video_timing_gen
module tb_video_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // default-parameter instance A: line, frame, half-rate tests
    logic ra = 1'b0, pa = 1'b1;
    logic [8:0] hpa, vpa;
    logic hsa, vsa, dna, hbka, vbka, lsa, fsa;
    logic [7:0] fca;
    video_timing_gen u_a (
        .clk(clk), .reset(ra), .pix_en(pa), .hpos(hpa), .vpos(vpa), .hsync(hsa), .vsync(vsa),
        .display_on(dna), .hblank(hbka), .vblank(vbka), .line_start(lsa), .frame_start(fsa),
        .frame_count(fca)
    );

    // default-parameter instance C: mid-frame asynchronous reset
    logic rc = 1'b0, pc = 1'b1;
    logic [8:0] hpc, vpc;
    logic hsc, vsc, dnc, hbkc, vbkc, lsc, fsc;
    logic [7:0] fcc;
    video_timing_gen u_c (
        .clk(clk), .reset(rc), .pix_en(pc), .hpos(hpc), .vpos(vpc), .hsync(hsc), .vsync(vsc),
        .display_on(dnc), .hblank(hbkc), .vblank(vbkc), .line_start(lsc), .frame_start(fsc),
        .frame_count(fcc)
    );

    // tiny raster instance B: inverted polarity, 2-bit frame counter, 8x6 raster
    logic rb = 1'b0, pb = 1'b1;
    logic [2:0] hpb, vpb;
    logic hsb, vsb, dnb, hbkb, vbkb, lsb, fsb;
    logic [1:0] fcb;
    video_timing_gen #(
        .H_DISPLAY(4), .H_BACK(1), .H_FRONT(1), .H_SYNC(2),
        .V_DISPLAY(3), .V_TOP(1), .V_BOTTOM(1), .V_SYNC(1),
        .H_BITS(3), .V_BITS(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_BITS(2)
    ) u_b (
        .clk(clk), .reset(rb), .pix_en(pb), .hpos(hpb), .vpos(vpb), .hsync(hsb), .vsync(vsb),
        .display_on(dnb), .hblank(hbkb), .vblank(vbkb), .line_start(lsb), .frame_start(fsb),
        .frame_count(fcb)
    );

    typedef struct packed {
        logic        r;
        logic        p;
        logic [14:0] e;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic p, input int h, input int v,
                                input logic hs, input logic vs, input logic d, input logic hbk,
                                input logic vbk, input logic ls, input logic fs, input int fc);
        vec_t t;
        t.r = r;
        t.p = p;
        t.e = {3'(h), 3'(v), hs, vs, d, hbk, vbk, ls, fs, 2'(fc)};
        return t;
    endfunction

    function automatic logic [14:0] got_b();
        return {hpb, vpb, hsb, vsb, dnb, hbkb, vbkb, lsb, fsb, fcb};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            begin : branch_a
                int hs_cnt, hs_win, line_err, hb_first, vs_cnt, vs_win, fs_cnt, vb_first, ls_cnt, d_err;
                repeat (3) step();
                chk("A reset hpos", hpa, 0);
                chk("A reset vpos", vpa, 0);
                chk("A reset hsync", hsa, 0);
                chk("A reset vsync", vsa, 0);
                chk("A reset display_on", dna, 1);
                chk("A reset hblank", hbka, 0);
                chk("A reset vblank", vbka, 0);
                chk("A reset strobes", {lsa, fsa}, 0);
                chk("A reset frame_count", fca, 0);
                @(negedge clk);
                ra = 1'b1;
                step();
                chk("A first frame_start", fsa, 1);
                chk("A first line_start", lsa, 1);
                hs_cnt = 0; hs_win = 0; line_err = 0; hb_first = -1;
                for (int i = 0; i < 309; i++) begin
                    if (hpa != 9'(i) || vpa != 0) line_err++;
                    hs_cnt += int'(hsa);
                    if (hsa && (hpa < 263 || hpa > 285)) hs_win++;
                    if (hbka && hb_first < 0) hb_first = int'(hpa);
                    step();
                end
                chk("A line hpos sequence errors", line_err, 0);
                chk("A hsync active clocks", hs_cnt, 23);
                chk("A hsync outside window", hs_win, 0);
                chk("A hblank first hpos", hb_first, 256);
                chk("A wrap hpos", hpa, 0);
                chk("A wrap vpos", vpa, 1);
                chk("A wrap line_start", lsa, 1);
                chk("A wrap frame_start", fsa, 0);
                vs_cnt = 0; vs_win = 0; fs_cnt = 0; vb_first = -1; d_err = 0;
                for (int k = 309; k < 80958; k++) begin
                    vs_cnt += int'(vsa);
                    fs_cnt += int'(fsa);
                    if (vsa != (vpa >= 254 && vpa <= 256)) vs_win++;
                    if (dna != (hpa < 256 && vpa < 240)) d_err++;
                    if (vbka && vb_first < 0) vb_first = int'(vpa);
                    step();
                end
                chk("A vsync active clocks", vs_cnt, 927);
                chk("A vsync window errors", vs_win, 0);
                chk("A display_on errors", d_err, 0);
                chk("A frame_start inside frame", fs_cnt, 0);
                chk("A vblank first vpos", vb_first, 240);
                chk("A frame end position", {hpa, vpa}, 0);
                chk("A frame_count after frame", fca, 1);
                chk("A frame_start at new frame", fsa, 1);
                ls_cnt = 0; line_err = 0;
                for (int i = 0; i < 618; i++) begin
                    if (i > 0) @(negedge clk);
                    pa = i[0];
                    #1;
                    if (hpa != 9'(i / 2) || vpa != 0) line_err++;
                    ls_cnt += int'(lsa);
                end
                @(negedge clk);
                pa = 1'b1;
                #1;
                chk("A half-rate hold errors", line_err, 0);
                chk("A half-rate line_start pulses", ls_cnt, 1);
                chk("A half-rate end position", {hpa, vpa}, {9'd0, 9'd1});
                chk("A half-rate next line_start", lsa, 1);
            end
            begin : branch_c
                logic found;
                found = 1'b0;
                repeat (2) step();
                rc = 1'b1;
                for (int i = 0; i < 20000 && !found; i++) begin
                    step();
                    found = hpc == 100 && vpc == 50;
                end
                chk("C reached hpos 100 vpos 50", found, 1);
                #1;
                rc = 1'b0;
                #1;
                chk("C async reset hpos", hpc, 0);
                chk("C async reset vpos", vpc, 0);
                chk("C async reset syncs", {hsc, vsc}, 0);
                chk("C async reset blank flags", {dnc, hbkc, vbkc}, 3'b100);
                chk("C async reset strobes", {lsc, fsc}, 0);
                step();
                rc = 1'b1;
                step();
                chk("C restart frame_start", {fsc, hpc, vpc, fcc}, {1'b1, 9'd0, 9'd0, 8'd0});
                step();
                chk("C restart counting hpos", hpc, 1);
            end
            begin : branch_b
                vec_t tbl[14];
                int eh, ev, efc, errs, prev_fc;
                logic wrap;
                tbl[0]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[1]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[2]  = mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[3]  = mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0);
                tbl[4]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[5]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[6]  = mk(1, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[7]  = mk(1, 1, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[8]  = mk(1, 1, 4, 0, 1, 1, 0, 1, 0, 0, 0, 0);
                tbl[9]  = mk(1, 1, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0);
                tbl[10] = mk(1, 1, 6, 0, 0, 1, 0, 1, 0, 0, 0, 0);
                tbl[11] = mk(1, 1, 7, 0, 1, 1, 0, 1, 0, 0, 0, 0);
                tbl[12] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
                tbl[13] = mk(1, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0);
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    rb = tbl[i].r;
                    pb = tbl[i].p;
                    #1;
                    chk($sformatf("B table row %0d", i), got_b(), tbl[i].e);
                end
                eh = 1; ev = 1; efc = 0; errs = 0; prev_fc = 0; wrap = 1'b0;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    pb = (i % 3) != 2;
                    #1;
                    if (got_b() !== mk(1, pb, eh, ev, !(eh >= 5 && eh <= 6), ev != 4, eh < 4 && ev < 3,
                                       eh >= 4, ev >= 3, pb && eh == 0, pb && eh == 0 && ev == 0,
                                       efc).e) errs++;
                    if (prev_fc == 3 && fcb == 0) wrap = 1'b1;
                    prev_fc = int'(fcb);
                    if (pb) begin
                        if (eh == 7) begin
                            eh = 0;
                            if (ev == 5) begin
                                ev = 0;
                                efc = (efc + 1) % 4;
                            end else ev++;
                        end else eh++;
                    end
                end
                chk("B multi-frame errors", errs, 0);
                chk("B frame_count wrap 3 to 0", wrap, 1);
                @(negedge clk);
                pb = 1'b1;
                #1;
                chk("B pre-reset state", {hpb, vpb, vsb, fcb}, {3'd4, 3'd4, 1'b0, 2'd1});
                #1;
                rb = 1'b0;
                #1;
                chk("B async reset", got_b(), mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0).e);
                step();
                rb = 1'b1;
                step();
                chk("B restart", got_b(), mk(1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0).e);
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
